// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory access controller: op encodings,
// controller states and default memory geometry.
package dmem_pkg;

    localparam int DATA_W    = 64;
    localparam int DEPTH_DEF = 32;
    localparam int IDX_W_DEF = $clog2(DEPTH_DEF);

    localparam logic [1:0] OP_LDUR  = 2'b00;
    localparam logic [1:0] OP_STUR  = 2'b01;
    localparam logic [1:0] OP_LDURB = 2'b10;
    localparam logic [1:0] OP_STURB = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_MERGE  = 2'd2,
        ST_RESP   = 2'd3
    } state_e;

    // Word ops must sit on an 8-byte boundary; byte ops may use any lane.
    function automatic logic is_misaligned(input logic [1:0] op, input logic [2:0] lane);
        return ((op == OP_LDUR) || (op == OP_STUR)) && (lane != 3'd0);
    endfunction

endpackage

// File: rtl/dmem_access_ctrl_if.sv
// Request, response and dmem-side signals of the memory-stage controller.
interface dmem_access_ctrl_if;

    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [63:0] resp_rdata;
    logic        resp_fault;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic        mem_read;
    logic        mem_write;
    logic [63:0] mem_rdata;

    modport slave (
        input  req_valid, req_op, req_addr, req_wdata, resp_ready, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_fault,
               mem_addr, mem_wdata, mem_read, mem_write
    );

    modport master (
        output req_valid, req_op, req_addr, req_wdata, resp_ready, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_fault,
               mem_addr, mem_wdata, mem_read, mem_write
    );

endinterface

// File: rtl/dmem_access_ctrl_byte_lane_unit.sv
// Little-endian byte lane helper: extracts a zero-extended byte from a word
// and merges a byte into a word at the given lane.
module byte_lane_unit (
    input  logic [63:0] word_i,
    input  logic [2:0]  lane_i,
    input  logic [7:0]  byte_i,
    output logic [63:0] byte_o,
    output logic [63:0] merged_o
);

    logic [5:0] bit_base_s;

    assign bit_base_s = {lane_i, 3'b000};

    // Lane k occupies bits 8k+7:8k.
    always_comb begin
        byte_o                     = {56'd0, word_i[bit_base_s +: 8]};
        merged_o                   = word_i;
        merged_o[bit_base_s +: 8]  = byte_i;
    end

endmodule

// File: rtl/dmem_access_ctrl.sv
// Memory-stage controller: one load/store at a time, registered dmem strobes,
// read-modify-write for byte stores, valid/ready response with fault flag.
module dmem_access_ctrl
    import dmem_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic               clk,
    input  logic               rst,
    dmem_access_ctrl_if.slave  bus
);

    localparam int          IDX_W      = $clog2(DEPTH);
    localparam logic [63:0] ADDR_LIMIT = 64'(DEPTH) << 3;

    state_e      state_q, state_d;
    logic [1:0]  op_q, op_d;
    logic [2:0]  lane_q, lane_d;
    logic [7:0]  wbyte_q, wbyte_d;
    logic        req_ready_q, req_ready_d;
    logic        resp_valid_q, resp_valid_d;
    logic        resp_fault_q, resp_fault_d;
    logic [63:0] resp_rdata_q, resp_rdata_d;
    logic        mem_read_q, mem_read_d;
    logic        mem_write_q, mem_write_d;
    logic [63:0] mem_addr_q, mem_addr_d;
    logic [63:0] mem_wdata_q, mem_wdata_d;

    logic        fault_s;
    logic [63:0] lane_byte_s;
    logic [63:0] merged_s;

    byte_lane_unit u_lane (
        .word_i   (bus.mem_rdata),
        .lane_i   (lane_q),
        .byte_i   (wbyte_q),
        .byte_o   (lane_byte_s),
        .merged_o (merged_s)
    );

    assign fault_s = is_misaligned(bus.req_op, bus.req_addr[2:0]) ||
                     (bus.req_addr >= ADDR_LIMIT);

    // Next-state and next-output logic for the access sequence.
    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        lane_d       = lane_q;
        wbyte_d      = wbyte_q;
        resp_valid_d = resp_valid_q;
        resp_fault_d = resp_fault_q;
        resp_rdata_d = resp_rdata_q;
        mem_read_d   = mem_read_q;
        mem_write_d  = mem_write_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid && req_ready_q) begin
                    op_d    = bus.req_op;
                    lane_d  = bus.req_addr[2:0];
                    wbyte_d = bus.req_wdata[7:0];
                    if (fault_s) begin
                        state_d      = ST_RESP;
                        resp_valid_d = 1'b1;
                        resp_fault_d = 1'b1;
                        resp_rdata_d = 64'd0;
                    end else begin
                        state_d      = ST_ACCESS;
                        resp_fault_d = 1'b0;
                        mem_addr_d   = 64'(bus.req_addr[IDX_W+2:3]);
                        if (bus.req_op == OP_STUR) begin
                            mem_write_d = 1'b1;
                            mem_wdata_d = bus.req_wdata;
                        end else begin
                            mem_read_d  = 1'b1;
                        end
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                mem_read_d   = 1'b0;
                mem_write_d  = 1'b0;
                state_d      = ST_RESP;
                resp_valid_d = 1'b1;
                case (op_q)
                    OP_LDUR:  resp_rdata_d = bus.mem_rdata;
                    OP_LDURB: resp_rdata_d = lane_byte_s;
                    OP_STUR:  resp_rdata_d = 64'd0;
                    OP_STURB: begin
                        // Read half of the byte store done; write back the merged word.
                        state_d      = ST_MERGE;
                        resp_valid_d = 1'b0;
                        resp_rdata_d = 64'd0;
                        mem_write_d  = 1'b1;
                        mem_wdata_d  = merged_s;
                    end
                    default:  resp_rdata_d = 64'd0;
                endcase
            end
            ST_MERGE: begin
                mem_write_d  = 1'b0;
                state_d      = ST_RESP;
                resp_valid_d = 1'b1;
                resp_rdata_d = 64'd0;
            end
            ST_RESP: begin
                if (bus.resp_ready) begin
                    state_d      = ST_IDLE;
                    resp_valid_d = 1'b0;
                end else begin
                    state_d      = ST_RESP;
                end
            end
            default: begin
                state_d      = ST_IDLE;
                resp_valid_d = 1'b0;
                mem_read_d   = 1'b0;
                mem_write_d  = 1'b0;
            end
        endcase

        req_ready_d = (state_d == ST_IDLE);
    end

    // State, latched request and all externally visible output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            op_q         <= 2'd0;
            lane_q       <= 3'd0;
            wbyte_q      <= 8'd0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_fault_q <= 1'b0;
            resp_rdata_q <= 64'd0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_addr_q   <= 64'd0;
            mem_wdata_q  <= 64'd0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            lane_q       <= lane_d;
            wbyte_q      <= wbyte_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_fault_q <= resp_fault_d;
            resp_rdata_q <= resp_rdata_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
        end
    end

    assign bus.req_ready  = req_ready_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_fault = resp_fault_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.mem_read   = mem_read_q;
    assign bus.mem_write  = mem_write_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Self-checking bench for dmem_access_ctrl: directed cases, random traffic
// against an array-based memory model, back-pressure and mid-access reset.
module tb_dmem_access_ctrl;
    import dmem_pkg::*;

    localparam int DEPTH = 32;

    logic        clk;
    logic        rst;
    logic        load_mem;
    int          checks = 0;
    int          errors = 0;
    logic [63:0] dmem    [0:DEPTH-1];
    logic [63:0] ref_mem [0:DEPTH-1];
    logic [63:0] rd;

    dmem_access_ctrl_if bus();

    dmem_access_ctrl #(.DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] init_val(input int i);
        if (i == 10) return 64'd1540;
        if (i == 11) return 64'd2117;
        return 64'(i * 100);
    endfunction

    // Behavioural dmem: combinational read, write on rising edge while MEMWRITE.
    always @(posedge clk) begin
        if (load_mem) begin
            for (int i = 0; i < DEPTH; i++) dmem[i] <= init_val(i);
        end else if (bus.mem_write) begin
            dmem[bus.mem_addr[4:0]] <= bus.mem_wdata;
        end
    end
    assign bus.mem_rdata = dmem[bus.mem_addr[4:0]];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One full transaction with reference-model expectations.
    task automatic do_req(input logic [1:0] op, input logic [63:0] addr,
                          input logic [63:0] wdata, input int hold,
                          output logic [63:0] rdata_out);
        logic        exp_fault;
        int          idx, lane, exp_lat, exp_rd, exp_wr, cyc, nrd, nwr;
        logic [63:0] exp_rdata, exp_wdata, mask;
        bit          got;

        exp_fault = (addr >= 64'(DEPTH * 8)) ||
                    (((op == OP_LDUR) || (op == OP_STUR)) && (addr % 64'd8 != 64'd0));
        idx  = exp_fault ? 0 : int'(addr / 64'd8);
        lane = int'(addr % 64'd8);
        mask = 64'hFF << (8 * lane);
        exp_rdata = 64'd0;
        exp_wdata = 64'd0;
        exp_rd = 0;
        exp_wr = 0;
        if (exp_fault) begin
            exp_lat = 1;
        end else begin
            case (op)
                OP_LDUR:  begin exp_lat = 2; exp_rd = 1; exp_rdata = ref_mem[idx]; end
                OP_LDURB: begin exp_lat = 2; exp_rd = 1; exp_rdata = (ref_mem[idx] >> (8 * lane)) & 64'hFF; end
                OP_STUR:  begin exp_lat = 2; exp_wr = 1; exp_wdata = wdata; end
                default:  begin
                    exp_lat = 3; exp_rd = 1; exp_wr = 1;
                    exp_wdata = (ref_mem[idx] & ~mask) | ((wdata & 64'hFF) << (8 * lane));
                end
            endcase
        end

        @(negedge clk);
        chk("req_ready_idle", 64'(bus.req_ready), 64'd1);
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;

        cyc = 0; nrd = 0; nwr = 0; got = 1'b0;
        while (!got && cyc < 10) begin
            @(negedge clk);
            cyc++;
            if (bus.mem_read)  nrd++;
            if (bus.mem_write) begin
                nwr++;
                chk("mem_wdata", bus.mem_wdata, exp_wdata);
            end
            if (bus.mem_read || bus.mem_write) chk("mem_addr", bus.mem_addr, 64'(idx));
            if (bus.resp_valid) got = 1'b1;
        end
        chk("resp_latency", 64'(cyc), 64'(exp_lat));
        chk("read_pulses", 64'(nrd), 64'(exp_rd));
        chk("write_pulses", 64'(nwr), 64'(exp_wr));
        chk("resp_fault", 64'(bus.resp_fault), 64'(exp_fault));
        chk("resp_rdata", bus.resp_rdata, exp_rdata);
        rdata_out = bus.resp_rdata;

        repeat (hold) begin
            @(negedge clk);
            chk("hold_valid", 64'(bus.resp_valid), 64'd1);
            chk("hold_rdata", bus.resp_rdata, exp_rdata);
            chk("hold_fault", 64'(bus.resp_fault), 64'(exp_fault));
            chk("hold_req_ready", 64'(bus.req_ready), 64'd0);
            chk("hold_strobes", 64'({bus.mem_read, bus.mem_write}), 64'd0);
        end
        bus.resp_ready = 1'b1;
        @(negedge clk);
        bus.resp_ready = 1'b0;
        chk("resp_done", 64'(bus.resp_valid), 64'd0);
        chk("ready_after", 64'(bus.req_ready), 64'd1);

        if (!exp_fault && (op == OP_STUR || op == OP_STURB)) ref_mem[idx] = exp_wdata;
    endtask

    initial begin
        logic [1:0]  op;
        logic [63:0] addr;
        int          r;

        rst = 1'b1;
        load_mem = 1'b1;
        bus.req_valid  = 1'b0;
        bus.req_op     = 2'd0;
        bus.req_addr   = 64'd0;
        bus.req_wdata  = 64'd0;
        bus.resp_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_val(i);
        repeat (2) @(negedge clk);

        chk("rst_req_ready", 64'(bus.req_ready), 64'd1);
        chk("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
        chk("rst_resp_fault", 64'(bus.resp_fault), 64'd0);
        chk("rst_resp_rdata", bus.resp_rdata, 64'd0);
        chk("rst_strobes", 64'({bus.mem_read, bus.mem_write}), 64'd0);
        chk("rst_mem_addr", bus.mem_addr, 64'd0);
        chk("rst_mem_wdata", bus.mem_wdata, 64'd0);
        load_mem = 1'b0;
        rst = 1'b0;

        do_req(OP_LDUR, 64'd80, 64'd0, 0, rd);
        chk("ldur80", rd, 64'd1540);
        do_req(OP_LDURB, 64'd81, 64'd0, 0, rd);
        chk("ldurb81", rd, 64'h06);
        do_req(OP_STURB, 64'd88, 64'hAB, 0, rd);
        do_req(OP_LDUR, 64'd88, 64'd0, 1, rd);
        chk("ldur88_after_sturb", rd, 64'h8AB);
        do_req(OP_STUR, 64'd16, 64'hDEAD, 0, rd);
        do_req(OP_LDUR, 64'd16, 64'd0, 0, rd);
        chk("ldur16_after_stur", rd, 64'hDEAD);
        do_req(OP_LDUR, 64'd84, 64'd0, 0, rd);
        do_req(OP_LDURB, 64'd256, 64'd0, 0, rd);
        do_req(OP_LDUR, 64'd80, 64'd0, 3, rd);
        do_req(OP_STURB, 64'd255, 64'h5A, 3, rd);
        do_req(OP_LDUR, 64'd248, 64'd0, 0, rd);
        chk("ldur248_top_lane", rd >> 56, 64'h5A);

        // Reset while a byte store is in its read cycle.
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_op    = OP_STURB;
        bus.req_addr  = 64'd43;
        bus.req_wdata = 64'hEE;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        @(negedge clk);
        chk("sturb_access_read", 64'(bus.mem_read), 64'd1);
        rst = 1'b1;
        #1;
        chk("rst_mid_strobes", 64'({bus.mem_read, bus.mem_write}), 64'd0);
        chk("rst_mid_ready", 64'(bus.req_ready), 64'd1);
        @(negedge clk);
        chk("rst_mid_no_resp", 64'(bus.resp_valid), 64'd0);
        rst = 1'b0;
        do_req(OP_LDUR, 64'd40, 64'd0, 0, rd);
        chk("ldur40_unchanged", rd, 64'd500);

        for (int n = 0; n < 150; n++) begin
            op = 2'($urandom_range(0, 3));
            r  = int'($urandom_range(0, 9));
            if (r == 0)      addr = {$urandom, $urandom};
            else if (r == 1) addr = 64'd256 + 64'($urandom_range(0, 1000));
            else if (r < 5)  addr = 64'($urandom_range(0, DEPTH * 8 - 1));
            else             addr = 64'($urandom_range(0, DEPTH - 1)) * 64'd8;
            do_req(op, addr, {$urandom, $urandom}, int'($urandom_range(0, 3)), rd);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
